// File: rtl/mbr_fifo.sv
// mbr_fifo: memory buffer register with a DEPTH-entry queue in front of the
// registered output word. Keeps the classic "preset at reset, hold last value"
// output, and adds bypass mode for single-register timing when the queue is empty.
module mbr_fifo #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(8'h02)
) (
    input  logic                       MBUF_clk,
    input  logic                       MBUF_rst,
    input  logic [WIDTH-1:0]           MBUF_in,
    input  logic                       MBUF_we,
    input  logic                       MBUF_re,
    input  logic                       MBUF_bypass,
    output logic [WIDTH-1:0]           MBUF_out,
    output logic                       MBUF_empty,
    output logic                       MBUF_full,
    output logic [$clog2(DEPTH+1)-1:0] MBUF_count,
    output logic                       MBUF_ovf,
    output logic                       MBUF_udf
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic bypass_act;
    logic pop_ok;
    logic push_ok;
    logic bypass_wr;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of 2).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Accept decisions; all based on registered status, never on output paths.
    always_comb begin
        bypass_act = MBUF_bypass & empty_q;
        pop_ok     = MBUF_re & ~empty_q;
        push_ok    = MBUF_we & ~bypass_act & (~full_q | pop_ok);
        bypass_wr  = MBUF_we & bypass_act;
    end

    // Next-state computation for pointers, storage, output word and status.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = MBUF_in;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end

        // Output reloads only on an accepted pop or a bypass write.
        if (pop_ok) begin
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else if (bypass_wr) begin
            out_d = MBUF_in;
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));

        // Sticky error flags: a dropped push, or a pop on an empty non-bypassed queue.
        if (MBUF_we && full_q && !pop_ok) begin
            ovf_d = 1'b1;
        end
        if (MBUF_re && empty_q && !MBUF_bypass) begin
            udf_d = 1'b1;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge MBUF_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (MBUF_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= RESET_VAL;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Queue storage; a write during reset is harmless since pointers and count restart.
    always_ff @(posedge MBUF_clk) begin
        // NOTE: storage is not reset; entries are only read after being written.
        mem_q <= mem_d;
    end

    assign MBUF_out   = out_q;
    assign MBUF_empty = empty_q;
    assign MBUF_full  = full_q;
    assign MBUF_count = count_q;
    assign MBUF_ovf   = ovf_q;
    assign MBUF_udf   = udf_q;

endmodule

// File: tb/tb_mbr_fifo.sv
// Testbench for mbr_fifo: two instances (DEPTH=4 and DEPTH=3) share the same
// stimulus. A queue-based reference model predicts each cycle's outputs, the
// prediction is pushed to a scoreboard, and a monitor compares after each edge.
module tb_mbr_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we  = 1'b0;
    logic       re  = 1'b0;
    logic       byp = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] out4, out3;
    logic [2:0] cnt4;
    logic [1:0] cnt3;
    logic       emp4, full4, ovf4, udf4;
    logic       emp3, full3, ovf3, udf3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mbr_fifo #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h02)) u_dut4 (
        .MBUF_clk   (clk),
        .MBUF_rst   (rst),
        .MBUF_in    (din),
        .MBUF_we    (we),
        .MBUF_re    (re),
        .MBUF_bypass(byp),
        .MBUF_out   (out4),
        .MBUF_empty (emp4),
        .MBUF_full  (full4),
        .MBUF_count (cnt4),
        .MBUF_ovf   (ovf4),
        .MBUF_udf   (udf4)
    );

    mbr_fifo #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h02)) u_dut3 (
        .MBUF_clk   (clk),
        .MBUF_rst   (rst),
        .MBUF_in    (din),
        .MBUF_we    (we),
        .MBUF_re    (re),
        .MBUF_bypass(byp),
        .MBUF_out   (out3),
        .MBUF_empty (emp3),
        .MBUF_full  (full3),
        .MBUF_count (cnt3),
        .MBUF_ovf   (ovf3),
        .MBUF_udf   (udf3)
    );

    // Expected outputs of both instances after one edge (index 0: DEPTH=4, 1: DEPTH=3).
    typedef struct packed {
        logic [1:0][7:0] out;
        logic [1:0][7:0] cnt;
        logic [1:0]      empty;
        logic [1:0]      full;
        logic [1:0]      ovf;
        logic [1:0]      udf;
    } exp_t;

    exp_t       exp_q [$];

    // Reference model state: the stored words as a plain queue, plus output and flags.
    logic [7:0] mq [2][$];
    logic [7:0] m_out [2];
    logic       m_ovf [2];
    logic       m_udf [2];

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input int k, input logic r, input logic w, input logic p,
                              input logic b, input logic [7:0] d);
        bit emp, ful, pop_acc, push_acc;
        if (r) begin
            mq[k].delete();
            m_out[k] = 8'h02;
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
            return;
        end
        emp = (mq[k].size() == 0);
        ful = (mq[k].size() == depth_of(k));
        if (b && emp) begin
            if (w) m_out[k] = d;
            return;
        end
        pop_acc  = p && !emp;
        push_acc = w && (!ful || pop_acc);
        if (p && emp)    m_udf[k] = 1'b1;
        if (w && !push_acc) m_ovf[k] = 1'b1;
        if (pop_acc)  m_out[k] = mq[k].pop_front();
        if (push_acc) mq[k].push_back(d);
    endtask

    // Drive one cycle of inputs and record the model's prediction for that edge.
    task automatic step(input logic r, input logic w, input logic p, input logic b,
                        input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rst = r;
        we  = w;
        re  = p;
        byp = b;
        din = d;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, w, p, b, d);
            e.out[k]   = m_out[k];
            e.cnt[k]   = 8'(mq[k].size());
            e.empty[k] = (mq[k].size() == 0);
            e.full[k]  = (mq[k].size() == depth_of(k));
            e.ovf[k]   = m_ovf[k];
            e.udf[k]   = m_udf[k];
        end
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compare both instances just after every rising edge with a pending prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("d4 out",   32'(out4),  32'(e.out[0]));
                check("d4 count", 32'(cnt4),  32'(e.cnt[0]));
                check("d4 empty", 32'(emp4),  32'(e.empty[0]));
                check("d4 full",  32'(full4), 32'(e.full[0]));
                check("d4 ovf",   32'(ovf4),  32'(e.ovf[0]));
                check("d4 udf",   32'(udf4),  32'(e.udf[0]));
                check("d3 out",   32'(out3),  32'(e.out[1]));
                check("d3 count", 32'(cnt3),  32'(e.cnt[1]));
                check("d3 empty", 32'(emp3),  32'(e.empty[1]));
                check("d3 full",  32'(full3), 32'(e.full[1]));
                check("d3 ovf",   32'(ovf3),  32'(e.ovf[1]));
                check("d3 udf",   32'(udf3),  32'(e.udf[1]));
            end
        end
    end

    initial begin
        // Reset value, then idle.
        do_reset();
        repeat (3) idle();

        // Fill and drain.
        for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i));
        repeat (4) pop();
        idle();

        // Overflow while full, then drain in order.
        for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i));
        push(8'hFF);
        repeat (4) pop();

        // Full push + pop in the same cycle.
        for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i));
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        repeat (4) pop();

        // Underflow, then empty push + pop (no fall-through).
        pop();
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C);
        pop();

        // Wrap-around with interleaved push/pop pairs.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push(8'h10 + 8'(i));
            pop();
        end

        // Bypass on empty queue: write goes straight to the output, pop ignored.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Bypass has no effect once data is queued.
        push(8'h21);
        push(8'h22);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h23);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Reset mid-operation discards queued data.
        push(8'h31);
        do_reset();
        idle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(3) == 0), 8'($urandom));
        end
        idle();

        // Let the monitor consume the remaining predictions.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d predictions left unchecked", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
